fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch controller sitting between the combinational instruction memory and decode. It owns the program counter and drives the memory word address every cycle. It buffers fetched {pc, instruction} pairs in a small prefetch FIFO and hands them to decode over a valid/ready handshake. It also handles control-flow redirects (branch/jump) and a fetch-halt request.

## Interface
- RESET_PC, default 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- FIFO_DEPTH, default 4: prefetch entries; power of two, at least 2.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  32  byte address to instruction memory; equals fetch PC; bits [1:0] always 0.
- imem_data  in  32  instruction word returned combinationally for imem_addr in the same cycle.
- inst_valid  out  1  FIFO head holds a valid entry.
- inst_ready  in  1  decode accepts the head this cycle.
- inst_data  out  32  instruction at the FIFO head.
- inst_pc  out  32  PC of the FIFO head.
- redirect_valid  in  1  single-cycle pulse; load redirect_pc and flush.
- redirect_pc  in  32  redirect target; bits [1:0] are forced to 0 internally.
- halt_req  in  1  level; while high, no new fetches are pushed.
- halted  out  1  state is HALT.

## Operation
- State machine has two states, FETCH and HALT. The next state is HALT if halt_req is 1, else FETCH, evaluated every cycle including redirect cycles. halted = (state == HALT).
- Push condition: state FETCH, no redirect_valid, and (count < FIFO_DEPTH or pop this cycle). On push, write {imem_addr, imem_data} to the tail and set fetch_pc <= fetch_pc + 4.
- Pop condition: inst_valid && inst_ready. A pop is honoured even in a redirect cycle, so decode sees the transfer as complete.
- Redirect: fetch_pc <= {redirect_pc[31:2], 2'b00}. The FIFO is emptied, with count forced to 0 regardless of pop or push. No push happens that cycle. A redirect is accepted in both FETCH and HALT.
- fetch_pc arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0. The memory's address folding is not the controller's concern.
- Full FIFO with no pop: fetch_pc holds, imem_addr stays stable, and nothing is pushed. Full with a pop: push and pop occur together and count is unchanged.
- Empty FIFO: inst_valid = 0, and inst_data and inst_pc are driven to 0.
- Entering HALT does not flush; the FIFO continues to drain to decode.

## Timing
- Reset values: fetch_pc = RESET_PC, imem_addr = RESET_PC, count = 0, inst_valid = 0, inst_data = 0, inst_pc = 0, state = FETCH, halted = 0.
- Reset takes priority over everything. Asserting rst mid-operation discards the FIFO contents and any same-cycle redirect.
- First cycle after rst falls: imem_addr = RESET_PC and the entry is pushed. inst_valid = 1 on the next cycle.
- Push-to-valid latency: 1 cycle, since the FIFO output is registered. There is no same-cycle bypass.
- Redirect pulse in cycle N:
  - cycle N+1: inst_valid = 0 and imem_addr = redirect target.
  - cycle N+2: inst_valid = 1, with inst_pc = target.
- Sustained throughput: 1 instruction per cycle while inst_ready = 1 and state = FETCH.
- halt_req high in cycle N: a push can still occur in N, the last push. halted = 1 from N+1.
- halt_req low in cycle M: halted = 0 and pushes resume in M+1.

## Configuration
- FETCH_CTRL_STATS_EN defined: adds two ports, both reset to 0 and wrapping at 2^32.
  - stat_fetched (out, 32): counts pushes.
  - stat_flushes (out, 32): counts accepted redirects.
- FETCH_CTRL_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.

## Structure
- Package fetch_pkg:
  - constant DEFAULT_RESET_PC;
  - typedef fetch_entry_t {pc[31:0], instr[31:0]};
  - enum fetch_state_t {FETCH, HALT}.
- Sub-module fetch_fifo: parameterised synchronous FIFO of fetch_entry_t. Ports: push, pop, flush, full, empty, count; flush has priority over push/pop. PC, state and redirect logic stay in fetch_ctrl.

## Test plan
- Reset release, inst_ready = 1, memory words 0x11, 0x22, 0x33 at 0x0, 0x4, 0x8: inst_pc sequence is 0x0, 0x4, 0x8 with matching inst_data, first valid 1 cycle after reset release.
- inst_ready = 0 for 10 cycles (FIFO_DEPTH = 4): exactly 4 pushes, then imem_addr holds at 0x10. Raising inst_ready gives back-to-back entries with no bubble.
- redirect_valid with redirect_pc = 0x43 while the FIFO holds 3 entries: the next cycle inst_valid = 0 and imem_addr = 0x40; two cycles later inst_pc = 0x40. Stale entries are never presented.
- halt_req held high for 5 cycles with inst_ready = 1: the FIFO drains, then inst_valid = 0 and halted = 1. Releasing halt_req resumes fetch at the next sequential PC.
- RESET_PC = 32'hFFFF_FFF8: inst_pc sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst pulsed while the FIFO is full and a redirect is asserted: the next cycle inst_valid = 0 and imem_addr = RESET_PC. With FETCH_CTRL_STATS_EN defined, both stat counters read 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries; registered storage, zeroed head when empty.
// Flush has priority over push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             wr_entry,
    output fetch_entry_t             rd_entry,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Storage needs no reset: the count alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    assign count    = count_q;
    assign full     = (count_q == FULL_COUNT);
    assign empty    = (count_q == '0);
    assign rd_entry = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, fills the prefetch FIFO, handles redirect/halt.
// Optional counters stat_fetched/stat_flushes are built when FETCH_CTRL_STATS_EN is defined.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        halted
`ifdef FETCH_CTRL_STATS_EN
    ,
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_flushes
`endif
);

    fetch_state_t   state;
    fetch_state_t   next_state;
    logic [31:0]    fetch_pc;
    logic           push;
    logic           pop;
    logic           full;
    logic           empty;
    fetch_entry_t   wr_entry;
    fetch_entry_t   head;
    logic [$clog2(FIFO_DEPTH):0] count_unused;
    logic           redirect_lsb_unused;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
        end else begin
            state <= next_state;
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
            end else if (push) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
        end
    end

    always_comb begin
        next_state = state;
        if (halt_req) begin
            next_state = HALT;
        end else begin
            next_state = FETCH;
        end
    end

    // A pop during a full cycle frees the slot the same-cycle push lands in.
    assign pop  = inst_valid && inst_ready;
    assign push = (state == FETCH) && !redirect_valid && (!full || pop);

    assign wr_entry.pc    = fetch_pc;
    assign wr_entry.instr = imem_data;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .flush    (redirect_valid),
        .wr_entry (wr_entry),
        .rd_entry (head),
        .full     (full),
        .empty    (empty),
        .count    (count_unused)
    );

    assign redirect_lsb_unused = ^redirect_pc[1:0];

    assign imem_addr  = fetch_pc;
    assign inst_valid = !empty;
    assign inst_data  = head.instr;
    assign inst_pc    = head.pc;
    assign halted     = (state == HALT);

`ifdef FETCH_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_fetched <= '0;
            stat_flushes <= '0;
        end else begin
            if (push) begin
                stat_fetched <= stat_fetched + 32'd1;
            end
            if (redirect_valid) begin
                stat_flushes <= stat_flushes + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        inst_ready;

    logic [31:0] imem_addr, imem_data, inst_data, inst_pc;
    logic        inst_valid, halted;
    logic [31:0] imem_addr2, imem_data2, inst_data2, inst_pc2;
    logic        inst_valid2, halted2;
`ifdef FETCH_CTRL_STATS_EN
    logic [31:0] stat_fetched, stat_flushes, stat_fetched2, stat_flushes2;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_pc;
    bit          m_halted;
    logic [31:0] m_fetched;
    logic [31:0] m_flushes;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h11;
            32'h4:   return 32'h22;
            32'h8:   return 32'h33;
            default: return a ^ 32'hDEAD_BEEF;
        endcase
    endfunction

    assign imem_data  = mem_word(imem_addr);
    assign imem_data2 = mem_word(imem_addr2);

    fetch_ctrl #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .halted         (halted)
`ifdef FETCH_CTRL_STATS_EN
        ,
        .stat_fetched   (stat_fetched),
        .stat_flushes   (stat_flushes)
`endif
    );

    fetch_ctrl #(.RESET_PC(WRAP_PC), .FIFO_DEPTH(DEPTH)) dut_wrap (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr2),
        .imem_data      (imem_data2),
        .inst_valid     (inst_valid2),
        .inst_ready     (1'b1),
        .inst_data      (inst_data2),
        .inst_pc        (inst_pc2),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .halt_req       (1'b0),
        .halted         (halted2)
`ifdef FETCH_CTRL_STATS_EN
        ,
        .stat_fetched   (stat_fetched2),
        .stat_flushes   (stat_flushes2)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs, compares outputs with the model, advances the
    // model across the clock edge, and returns just after the edge has settled.
    task automatic applyStimulus(input bit r, input bit rv, input logic [31:0] rpc,
                                 input bit h, input bit rdy, input bit chk);
        bit do_pop;
        bit do_push;
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt_req       = h;
        inst_ready     = rdy;
        if (chk) begin
            checkOutput("imem_addr",  imem_addr, m_pc);
            checkOutput("inst_valid", {31'b0, inst_valid}, {31'b0, m_q.size() > 0});
            checkOutput("inst_pc",    inst_pc,   (m_q.size() > 0) ? m_q[0].pc : 32'h0);
            checkOutput("inst_data",  inst_data, (m_q.size() > 0) ? m_q[0].instr : 32'h0);
            checkOutput("halted",     {31'b0, halted}, {31'b0, m_halted});
`ifdef FETCH_CTRL_STATS_EN
            checkOutput("stat_fetched", stat_fetched, m_fetched);
            checkOutput("stat_flushes", stat_flushes, m_flushes);
`endif
        end
        if (r) begin
            m_q.delete();
            m_pc      = 32'h0;
            m_halted  = 1'b0;
            m_fetched = 32'h0;
            m_flushes = 32'h0;
        end else begin
            do_pop  = (m_q.size() > 0) && rdy;
            do_push = !m_halted && !rv && ((m_q.size() < DEPTH) || do_pop);
            if (do_pop) void'(m_q.pop_front());
            if (rv) begin
                m_q.delete();
                m_pc = rpc & ~32'h3;
                m_flushes++;
            end else if (do_push) begin
                m_q.push_back('{pc: m_pc, instr: mem_word(m_pc)});
                m_pc = m_pc + 32'd4;
                m_fetched++;
            end
            m_halted = h;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0; inst_ready = 1'b0;
        @(negedge clk);
        #1;

        $display("[TB] reset release and sequential fetch");
        doReset();
        checkOutput("reset_valid",  {31'b0, inst_valid}, 32'h0);
        checkOutput("reset_addr",   imem_addr, 32'h0);
        checkOutput("reset_data",   inst_data, 32'h0);
        checkOutput("reset_halted", {31'b0, halted}, 32'h0);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("first_pc",   inst_pc,   32'h0);
        checkOutput("first_data", inst_data, 32'h11);
        checkOutput("wrap_pc0",   inst_pc2,  32'hFFFF_FFF8);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("second_pc",   inst_pc,   32'h4);
        checkOutput("second_data", inst_data, 32'h22);
        checkOutput("wrap_pc1",    inst_pc2,  32'hFFFF_FFFC);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("third_pc",   inst_pc,   32'h8);
        checkOutput("third_data", inst_data, 32'h33);
        checkOutput("wrap_pc2",   inst_pc2,  32'h0);

        $display("[TB] stall with full FIFO");
        doReset();
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("stall_addr",  imem_addr, 32'h10);
        checkOutput("stall_valid", {31'b0, inst_valid}, 32'h1);
        checkOutput("stall_pc",    inst_pc,   32'h0);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 1, 1);

        $display("[TB] redirect with 3 buffered entries");
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 32'h43, 0, 0, 1);
        checkOutput("redir_valid", {31'b0, inst_valid}, 32'h0);
        checkOutput("redir_addr",  imem_addr, 32'h40);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("redir_pc",    inst_pc, 32'h40);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 1);

        $display("[TB] halt and resume");
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, 1, 1);
        checkOutput("halt_valid",  {31'b0, inst_valid}, 32'h0);
        checkOutput("halt_halted", {31'b0, halted}, 32'h1);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("resume_halted", {31'b0, halted}, 32'h0);
        checkOutput("resume_addr",   imem_addr, 32'h10);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("resume_pc",     inst_pc, 32'h10);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5, $urandom,
                          $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 70, 1);
        end

        $display("[TB] reset over full FIFO and redirect");
        applyStimulus(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(1, 1, 32'h80, 0, 0, 1);
        checkOutput("rst_valid", {31'b0, inst_valid}, 32'h0);
        checkOutput("rst_addr",  imem_addr, 32'h0);
`ifdef FETCH_CTRL_STATS_EN
        checkOutput("rst_stat_fetched", stat_fetched, 32'h0);
        checkOutput("rst_stat_flushes", stat_flushes, 32'h0);
`endif
        applyStimulus(0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
